phase_sequencer: RTL and testbench

Phase sequencer for the multicycle processor core. It turns the operator `exec` button and the decoder's `stop_flag` into the run/stop state, the `phase` count and the `p0` strobe that drive the combinational control decoder. It also counts retired instructions. It sits between the top level and the control decoder, and is the only block in the core that holds execution state.

---
 rtl/cpu_ctrl_pkg.sv | 24 ++
 rtl/btn_sync_edge.sv | 30 +++
 rtl/phase_sequencer.sv | 146 ++++++++++++++
 tb/tb_phase_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multicycle core control path:
// sequencer state encoding, named phase numbers and the default phase count.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } seq_state_t;

    localparam int PH_FETCH  = 0;
    localparam int PH_DECODE = 1;
    localparam int PH_EXEC   = 2;
    localparam int PH_MEM    = 3;
    localparam int PH_WB     = 4;

    localparam int NUM_PHASES_DEF = 5;

    // Phase number of the final phase of an instruction.
    function automatic logic [2:0] last_phase(input int num_phases);
        return 3'(num_phases - 1);
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Operator button conditioner: SYNC_STAGES-deep synchronizer for an
// asynchronous level input, followed by a history flop for rising-edge
// detection. The rise output is decoded from flops only.
module btn_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   hist_reg;

    // Shift the raw button through the synchronizer chain and keep one
    // cycle of history of the settled value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_reg <= '0;
            hist_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn};
            hist_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign rise = sync_reg[SYNC_STAGES-1] & ~hist_reg;

endmodule

// File: rtl/phase_sequencer.sv
// Phase sequencer for the multicycle core: turns the exec button and the
// decoder's stop_flag into IDLE/RUN/HALT state, the phase count, the p0
// strobe and a retired-instruction counter.
// Optional feature macro: PHASE_SEQ_STEP_EN adds a single-step button.
module phase_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int NUM_PHASES  = NUM_PHASES_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exec,
    input  logic             stop_flag,
`ifdef PHASE_SEQ_STEP_EN
    input  logic             step,
`endif
    output logic [2:0]       phase,
    output logic             p0,
    output logic             executing,
    output logic             halted,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] LAST_PH = last_phase(NUM_PHASES);

    seq_state_t       state_reg, state_next;
    logic [2:0]       phase_reg, phase_next;
    logic             stop_req_reg, stop_req_next;
    logic             halt_req_reg, halt_req_next;
    logic [CNT_W-1:0] retired_reg, retired_next;
    logic             exec_rise;

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_exec_sync (
        .clk  (clk),
        .rst  (rst),
        .btn  (exec),
        .rise (exec_rise)
    );

`ifdef PHASE_SEQ_STEP_EN
    logic step_rise;

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_step_sync (
        .clk  (clk),
        .rst  (rst),
        .btn  (step),
        .rise (step_rise)
    );
`endif

    // State, phase, sticky end-of-instruction requests and retire counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            phase_reg    <= 3'd0;
            stop_req_reg <= 1'b0;
            halt_req_reg <= 1'b0;
            retired_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            phase_reg    <= phase_next;
            stop_req_reg <= stop_req_next;
            halt_req_reg <= halt_req_next;
            retired_reg  <= retired_next;
        end
    end

    // Next-state logic: start on a button edge, step phases in RUN, and
    // decide HALT/IDLE/RUN only at the edge that ends the last phase.
    always_comb begin
        state_next    = state_reg;
        phase_next    = phase_reg;
        stop_req_next = stop_req_reg;
        halt_req_next = halt_req_reg;
        retired_next  = retired_reg;
        case (state_reg)
            ST_IDLE: begin
                if (exec_rise) begin
                    state_next    = ST_RUN;
                    phase_next    = 3'd0;
                    stop_req_next = 1'b0;
                    halt_req_next = 1'b0;
                end
`ifdef PHASE_SEQ_STEP_EN
                else if (step_rise) begin
                    // One-shot: the preset stop request ends the run
                    // after exactly one instruction.
                    state_next    = ST_RUN;
                    phase_next    = 3'd0;
                    stop_req_next = 1'b1;
                    halt_req_next = 1'b0;
                end
`endif
            end
            ST_HALT: begin
                if (exec_rise) begin
                    state_next    = ST_RUN;
                    phase_next    = 3'd0;
                    stop_req_next = 1'b0;
                    halt_req_next = 1'b0;
                end
            end
            ST_RUN: begin
                if (phase_reg == LAST_PH) begin
                    retired_next  = retired_reg + {{(CNT_W-1){1'b0}}, 1'b1};
                    phase_next    = 3'd0;
                    stop_req_next = 1'b0;
                    halt_req_next = 1'b0;
                    // Halt outranks an operator stop in the same instruction.
                    if (halt_req_reg || stop_flag) begin
                        state_next = ST_HALT;
                    end else if (stop_req_reg || exec_rise) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_RUN;
                    end
                end else begin
                    phase_next = phase_reg + 3'd1;
                    if (exec_rise) begin
                        stop_req_next = 1'b1;
                    end
                    if (stop_flag) begin
                        halt_req_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next    = ST_IDLE;
                phase_next    = 3'd0;
                stop_req_next = 1'b0;
                halt_req_next = 1'b0;
            end
        endcase
    end

    assign phase      = phase_reg;
    assign executing  = (state_reg == ST_RUN);
    assign halted     = (state_reg == ST_HALT);
    assign p0         = executing && (phase_reg == 3'd0);
    assign instr_done = executing && (phase_reg == LAST_PH);
    assign retired    = retired_reg;

endmodule

// File: tb/tb_phase_sequencer.sv
// Testbench for phase_sequencer: directed scenarios followed by random
// button/stop_flag/reset traffic, every cycle compared against a behavioural
// model built from run-length arithmetic and a queue of sampled inputs.
module tb_phase_sequencer;

    localparam int NP = 5;
    localparam int SS = 2;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          exec = 1'b0;
    logic          stop_flag = 1'b0;
`ifdef PHASE_SEQ_STEP_EN
    logic          step = 1'b0;
`endif
    logic [2:0]    phase;
    logic          p0;
    logic          executing;
    logic          halted;
    logic          instr_done;
    logic [CW-1:0] retired;

    int n_cmp = 0;
    int n_err = 0;

    // Model: mode 0=idle 1=run 2=halt; phase derived from cycles spent in RUN.
    int m_mode = 0;
    int m_run_cyc = 0;
    bit m_stop_seen = 1'b0;
    bit m_halt_seen = 1'b0;
    int m_count = 0;
    bit ex_q[$];
`ifdef PHASE_SEQ_STEP_EN
    bit st_q[$];
    bit m_step_in = 1'b0;
`endif

    always #5 clk = ~clk;

    phase_sequencer #(
        .NUM_PHASES  (NP),
        .SYNC_STAGES (SS),
        .CNT_W       (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .exec       (exec),
        .stop_flag  (stop_flag),
`ifdef PHASE_SEQ_STEP_EN
        .step       (step),
`endif
        .phase      (phase),
        .p0         (p0),
        .executing  (executing),
        .halted     (halted),
        .instr_done (instr_done),
        .retired    (retired)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_phase();
        return (m_mode == 1) ? (m_run_cyc % NP) : 0;
    endfunction

    task automatic start_run(input bit one_shot);
        m_mode      = 1;
        m_run_cyc   = 0;
        m_stop_seen = one_shot;
        m_halt_seen = 1'b0;
    endtask

    // Advance the model across one clock edge given the inputs seen there.
    task automatic model_edge(input bit r, input bit e, input bit s);
        bit er;
        bit sr;
        bit last;
        if (!r) begin
            m_mode = 0; m_run_cyc = 0; m_stop_seen = 0; m_halt_seen = 0; m_count = 0;
            ex_q.delete();
            for (int i = 0; i <= SS; i++) ex_q.push_back(1'b0);
`ifdef PHASE_SEQ_STEP_EN
            st_q.delete();
            for (int i = 0; i <= SS; i++) st_q.push_back(1'b0);
`endif
            return;
        end
        // ex_q[0] is the sample SS+... edges old; rise = next-oldest & ~oldest.
        er = ex_q[1] & ~ex_q[0];
        ex_q.push_back(e);
        void'(ex_q.pop_front());
        sr = 1'b0;
`ifdef PHASE_SEQ_STEP_EN
        sr = st_q[1] & ~st_q[0];
        st_q.push_back(m_step_in);
        void'(st_q.pop_front());
`endif
        case (m_mode)
            0: begin
                if (er) start_run(1'b0);
                else if (sr) start_run(1'b1);
            end
            2: if (er) start_run(1'b0);
            default: begin
                m_stop_seen |= er;
                m_halt_seen |= s;
                last = ((m_run_cyc % NP) == NP - 1);
                m_run_cyc++;
                if (last) begin
                    m_count = (m_count + 1) % (1 << CW);
                    if (m_halt_seen) m_mode = 2;
                    else if (m_stop_seen) m_mode = 0;
                    m_stop_seen = 0;
                    m_halt_seen = 0;
                end
            end
        endcase
    endtask

    task automatic check_all();
        chk("phase",      32'(phase),      32'(m_phase()));
        chk("p0",         32'(p0),         32'(m_mode == 1 && m_phase() == 0));
        chk("executing",  32'(executing),  32'(m_mode == 1));
        chk("halted",     32'(halted),     32'(m_mode == 2));
        chk("instr_done", 32'(instr_done), 32'(m_mode == 1 && m_phase() == NP - 1));
        chk("retired",    32'(retired),    32'(m_count));
    endtask

    task automatic tick();
        bit r, e, s;
        r = rst; e = exec; s = stop_flag;
`ifdef PHASE_SEQ_STEP_EN
        m_step_in = step;
`endif
        @(posedge clk);
        model_edge(r, e, s);
        #1;
        check_all();
    endtask

    task automatic run_until(input int p, input int budget);
        int n;
        n = 0;
        while (!(m_mode == 1 && m_phase() == p) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk("wait_phase_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        // Reset held for three cycles
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_exec", 32'(executing), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        rst = 1'b1;
        tick();

        // exec pulse: RUN visible after edge k+2
        exec = 1'b1;
        tick();
        tick();
        chk("start_not_yet", 32'(executing), 32'd0);
        tick();
        chk("start_run", 32'(executing), 32'd1);
        chk("start_p0", 32'(p0), 32'd1);
        exec = 1'b0;
        repeat (15) tick();
        chk("retired_3", 32'(retired), 32'd3);
        chk("phase_back_0", 32'(phase), 32'd0);

        // exec rises again during phase 1 -> finish instruction -> IDLE
        run_until(4, 10);
        exec = 1'b1;
        repeat (6) tick();
        chk("stop_idle_exec", 32'(executing), 32'd0);
        chk("stop_idle_phase", 32'(phase), 32'd0);
        chk("stop_idle_retired", 32'(retired), 32'd5);

        // stop_flag in phase 2 only -> HALT
        exec = 1'b0; tick();
        exec = 1'b1; repeat (3) tick();
        run_until(2, 10);
        stop_flag = 1'b1; tick();
        stop_flag = 1'b0; tick(); tick();
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_retired", 32'(retired), 32'd6);
        exec = 1'b0; tick();
        exec = 1'b1; repeat (3) tick();
        chk("halt_exit_run", 32'(executing), 32'd1);
        chk("halt_exit_halted", 32'(halted), 32'd0);

        // exec rise lands in phase 4 plus stop_flag in phase 3 -> HALT wins
        exec = 1'b0; tick(); tick();
        exec = 1'b1; tick();
        stop_flag = 1'b1; tick();
        stop_flag = 1'b0; tick();
        chk("both_halt", 32'(halted), 32'd1);

        // exec rise alone in phase 4 -> IDLE at that edge
        exec = 1'b0; tick();
        exec = 1'b1; repeat (3) tick();
        exec = 1'b0; tick(); tick();
        exec = 1'b1; repeat (3) tick();
        chk("ph4_rise_idle", 32'(executing), 32'd0);
        chk("ph4_rise_halted", 32'(halted), 32'd0);

        // reset during phase 3
        exec = 1'b0; tick();
        exec = 1'b1; repeat (3) tick();
        run_until(3, 10);
        rst = 1'b0; tick();
        chk("midrst_retired", 32'(retired), 32'd0);
        chk("midrst_exec", 32'(executing), 32'd0);
        chk("midrst_phase", 32'(phase), 32'd0);
        rst = 1'b1; exec = 1'b0; tick();

        // counter wrap (all-ones -> 0)
        exec = 1'b1; repeat (3) tick();
        for (int i = 0; i < 2000 && m_count != (1 << CW) - 1; i++) tick();
        chk("wrap_pre", 32'(retired), 32'((1 << CW) - 1));
        run_until(4, 10);
        tick();
        chk("wrap_zero", 32'(retired), 32'd0);

`ifdef PHASE_SEQ_STEP_EN
        // single step: exactly one instruction, then IDLE
        rst = 1'b0; exec = 1'b0; tick();
        rst = 1'b1; tick();
        step = 1'b1; repeat (3) tick();
        chk("step_run", 32'(executing), 32'd1);
        repeat (5) tick();
        chk("step_idle", 32'(executing), 32'd0);
        chk("step_retired", 32'(retired), 32'd1);
        // step and exec together: free run
        step = 1'b0; tick();
        step = 1'b1; exec = 1'b1; repeat (3) tick();
        repeat (10) tick();
        chk("step_exec_free", 32'(executing), 32'd1);
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) exec = ~exec;
            stop_flag = ($urandom_range(0, 11) == 0);
            rst = ($urandom_range(0, 199) != 0);
`ifdef PHASE_SEQ_STEP_EN
            if ($urandom_range(0, 9) == 0) step = ~step;
`endif
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
